// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_seq
//  Description : Streaming multi-precision adder. Operands arrive 16 bits per
//                beat, least-significant word first. Each word goes through
//                two 16-bit Sklansky prefix adders: the first adds A and B,
//                the second adds the inter-word carry. The sum words leave
//                through a one-entry registered valid/ready output stage.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  SklanskyAdder_16 : 16-bit divide-and-conquer parallel-prefix adder.
//  It has no carry input; the wrapper below adds a carry with a second pass.
// ----------------------------------------------------------------------------
module SklanskyAdder_16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum,
    output logic        o_co
);

    logic [15:0] w_p0;
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_g_nxt;
    logic [15:0] w_p_nxt;
    int          w_j;

    // Prefix tree: at level l, every bit whose l-th index bit is set merges
    // with the top bit of the block immediately to its right.
    always_comb begin
        w_p0    = i_a ^ i_b;
        w_g     = i_a & i_b;
        w_p     = w_p0;
        w_g_nxt = w_g;
        w_p_nxt = w_p;
        w_j     = 0;
        for (int l = 0; l < 4; l++) begin
            w_g_nxt = w_g;
            w_p_nxt = w_p;
            for (int i = 0; i < 16; i++) begin
                if (((i >> l) & 1) == 1) begin
                    w_j        = ((i >> l) << l) - 1;
                    w_g_nxt[i] = w_g[i] | (w_p[i] & w_g[w_j]);
                    w_p_nxt[i] = w_p[i] & w_p[w_j];
                end
            end
            w_g = w_g_nxt;
            w_p = w_p_nxt;
        end
    end

    // The carry into bit i is the group generate of bits [i-1:0].
    assign o_sum = w_p0 ^ {w_g[14:0], 1'b0};
    assign o_co  = w_g[15];

endmodule

// ----------------------------------------------------------------------------
//  wide_add_seq : top level
// ----------------------------------------------------------------------------
module wide_add_seq #(
    parameter int MAX_WORDS = 8,
    parameter int CW        = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [15:0]   A,
    input  logic [15:0]   B,
    input  logic          CI,
    input  logic          IN_LAST,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [15:0]   SUM,
    output logic          OUT_LAST,
    output logic          CO,
    output logic          OVF,
    output logic [CW-1:0] IDX,
    output logic          ERR
);

    localparam logic [CW-1:0] c_MAX_IDX = CW'(MAX_WORDS - 1);

    typedef enum logic [0:0] {
        ST_FIRST = 1'b0,
        ST_MID   = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_cr;

    logic          r_out_valid;
    logic [15:0]   r_sum;
    logic          r_out_last;
    logic          r_co;
    logic          r_ovf;
    logic [CW-1:0] r_idx;
    logic          r_err;

    logic          w_accept;
    logic          w_cin;
    logic [15:0]   w_s1;
    logic          w_c1;
    logic [15:0]   w_s2;
    logic          w_c2;
    logic          w_cout;
    logic          w_err;
    logic          w_last;
    logic          w_ovf;

    // The output stage can take a new word when empty or being drained.
    assign IN_READY = !r_out_valid | OUT_READY;
    assign w_accept = IN_VALID & IN_READY;

    // Word 0 uses the external carry-in; later words chain the stored carry.
    assign w_cin = (r_state == ST_FIRST) ? CI : r_cr;

    SklanskyAdder_16 u_add_ab (
        .i_a   (A),
        .i_b   (B),
        .o_sum (w_s1),
        .o_co  (w_c1)
    );

    SklanskyAdder_16 u_add_ci (
        .i_a   (w_s1),
        .i_b   ({15'b0, w_cin}),
        .o_sum (w_s2),
        .o_co  (w_c2)
    );

    // Only one of the two passes can carry: a carry out of the second pass
    // needs s1 = FFFF, which is impossible when the first pass carried.
    assign w_cout = w_c1 | w_c2;

    // An operand that fills the last index without IN_LAST is forcibly closed.
    assign w_err  = (r_cnt == c_MAX_IDX) & !IN_LAST;
    assign w_last = IN_LAST | w_err;
    assign w_ovf  = w_last & (A[15] == B[15]) & (w_s2[15] != A[15]);

    // Next-state logic: any closing word returns to FIRST.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_last ? ST_FIRST : ST_MID;
        end
    end

    // FSM state, word counter and inter-word carry advance on acceptance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_FIRST;
            r_cnt   <= '0;
            r_cr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= w_last ? '0 : (r_cnt + CW'(1));
                r_cr  <= w_last ? 1'b0 : w_cout;
            end
        end
    end

    // Output register: load on accept, clear valid on a pop with no refill.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_out_last  <= 1'b0;
            r_co        <= 1'b0;
            r_ovf       <= 1'b0;
            r_idx       <= '0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_sum       <= w_s2;
            r_out_last  <= w_last;
            r_co        <= w_cout & w_last;
            r_ovf       <= w_ovf;
            r_idx       <= r_cnt;
            r_err       <= w_err;
        end else if (OUT_READY) begin
            r_out_valid <= 1'b0;
        end
    end

    assign OUT_VALID = r_out_valid;
    assign SUM       = r_sum;
    assign OUT_LAST  = r_out_last;
    assign CO        = r_co;
    assign OVF       = r_ovf;
    assign IDX       = r_idx;
    assign ERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wide_add_seq
//  Description : Self-checking bench for wide_add_seq. Operands are modelled
//                as whole wide integers; expected sum words are sliced from
//                the full-width sum once each operand closes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_seq;

    localparam int MW = 8;
    localparam int CW = 4;

    typedef logic [23:0] ent_t;   // {sum, last, co, ovf, idx, err}

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [15:0]   A = '0;
    logic [15:0]   B = '0;
    logic          CI = 1'b0;
    logic          IN_LAST = 1'b0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b1;
    logic [15:0]   SUM;
    logic          OUT_LAST;
    logic          CO;
    logic          OVF;
    logic [CW-1:0] IDX;
    logic          ERR;

    int checks = 0;
    int errors = 0;

    ent_t obs_q[$];
    ent_t exp_q[$];

    logic [16*MW-1:0] m_a = '0;
    logic [16*MW-1:0] m_b = '0;
    logic             m_ci = 1'b0;
    int               m_n = 0;

    bit rnd_rdy = 1'b0;
    bit rdy_at_neg = 1'b0;

    wide_add_seq #(.MAX_WORDS(MW), .CW(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .CI        (CI),
        .IN_LAST   (IN_LAST),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SUM       (SUM),
        .OUT_LAST  (OUT_LAST),
        .CO        (CO),
        .OVF       (OVF),
        .IDX       (IDX),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Close the current operand: full-width add, then slice into words.
    task automatic model_close(input bit last_flag);
        logic [16*MW:0] s;
        ent_t e;
        bit co, ovf;
        s   = {1'b0, m_a} + {1'b0, m_b} + {{(16*MW){1'b0}}, m_ci};
        co  = s[16*m_n];
        ovf = (m_a[16*m_n-1] == m_b[16*m_n-1]) && (s[16*m_n-1] != m_a[16*m_n-1]);
        for (int i = 0; i < m_n; i++) begin
            if (i == m_n - 1)
                e = {s[16*i +: 16], 1'b1, co, ovf, 4'(i), !last_flag};
            else
                e = {s[16*i +: 16], 1'b0, 1'b0, 1'b0, 4'(i), 1'b0};
            exp_q.push_back(e);
        end
        m_a = '0;
        m_b = '0;
        m_n = 0;
    endtask

    task automatic model_push(input logic [15:0] a, input logic [15:0] b,
                              input logic ci, input logic last);
        if (m_n == 0) m_ci = ci;
        m_a[16*m_n +: 16] = a;
        m_b[16*m_n +: 16] = b;
        m_n++;
        if (last || m_n == MW) model_close(last);
    endtask

    // One clock: observe pops at the falling edge, then step past the rise.
    task automatic tick();
        @(negedge CLK);
        rdy_at_neg = IN_READY;
        if (!RST && OUT_VALID && OUT_READY)
            obs_q.push_back({SUM, OUT_LAST, CO, OVF, IDX, ERR});
        @(posedge CLK);
        #1;
        if (rnd_rdy) OUT_READY = 1'($urandom_range(0, 1));
    endtask

    task automatic send_word(input logic [15:0] a, input logic [15:0] b,
                             input logic ci, input logic last);
        bit acc;
        acc = 1'b0;
        IN_VALID = 1'b1;
        A = a; B = b; CI = ci; IN_LAST = last;
        for (int t = 0; t < 200 && !acc; t++) begin
            tick();
            acc = rdy_at_neg;
        end
        IN_VALID = 1'b0;
        chk("accept_bound", 32'(acc), 32'd1);
        model_push(a, b, ci, last);
    endtask

    task automatic drain_and_compare();
        rnd_rdy = 1'b0;
        OUT_READY = 1'b1;
        for (int t = 0; t < 20 && OUT_VALID; t++) tick();
        chk("drain_bound", 32'(OUT_VALID), 32'd0);
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk("sb_word", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        chk("obs_left", obs_q.size(), 0);
        chk("exp_left", exp_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(OUT_VALID), 0);
        chk({tag, "_sum"},   32'(SUM), 0);
        chk({tag, "_last"},  32'(OUT_LAST), 0);
        chk({tag, "_co"},    32'(CO), 0);
        chk({tag, "_ovf"},   32'(OVF), 0);
        chk({tag, "_idx"},   32'(IDX), 0);
        chk({tag, "_err"},   32'(ERR), 0);
    endtask

    initial begin
        int n;
        logic [15:0] wa, wb;

        // Reset state
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        chk_all_zero("reset");
        chk("reset_in_ready", 32'(IN_READY), 1);

        // Single word FFFF + 0001
        send_word(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        chk("t1_valid", 32'(OUT_VALID), 1);
        chk("t1_sum",   32'(SUM), 32'h0000);
        chk("t1_co",    32'(CO), 1);
        chk("t1_ovf",   32'(OVF), 0);
        chk("t1_last",  32'(OUT_LAST), 1);
        chk("t1_idx",   32'(IDX), 0);

        // 4-word carry ripple across every word
        for (int i = 0; i < 4; i++)
            send_word(16'hFFFF, (i == 0) ? 16'h0001 : 16'h0000, 1'b0, 1'(i == 3));
        chk("t2_co", 32'(CO), 1);
        drain_and_compare();

        // Carry-in and signed overflow
        send_word(16'h0000, 16'hFFFF, 1'b1, 1'b1);
        chk("t3_sum", 32'(SUM), 32'h0000);
        chk("t3_co",  32'(CO), 1);
        send_word(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        chk("t4_sum", 32'(SUM), 32'h8000);
        chk("t4_co",  32'(CO), 0);
        chk("t4_ovf", 32'(OVF), 1);
        drain_and_compare();

        // Backpressure for 5 cycles holding word 1 of a 3-word operand
        send_word(16'h0001, 16'h0002, 1'b0, 1'b0);
        send_word(16'h1234, 16'h1111, 1'b0, 1'b0);
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        A = 16'hAAAA; B = 16'h5555; CI = 1'b1; IN_LAST = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_in_ready", 32'(IN_READY), 0);
            chk("bp_valid",    32'(OUT_VALID), 1);
            chk("bp_sum",      32'(SUM), 32'h2345);
            chk("bp_idx",      32'(IDX), 1);
        end
        OUT_READY = 1'b1;
        send_word(16'hAAAA, 16'h5555, 1'b1, 1'b1);
        drain_and_compare();

        // Overlong operand: 9 words without IN_LAST, then close the 2nd one
        for (int i = 0; i < 9; i++) begin
            send_word(16'hFFFF, 16'h0000, 1'b1, 1'b0);
            if (i == 7) begin
                chk("err_flag", 32'(ERR), 1);
                chk("err_last", 32'(OUT_LAST), 1);
                chk("err_idx",  32'(IDX), 7);
                chk("err_co",   32'(CO), 1);
            end
        end
        chk("err_new_idx", 32'(IDX), 0);
        chk("err_new_sum", 32'(SUM), 32'h0000);
        send_word(16'h0003, 16'h0004, 1'b0, 1'b1);
        drain_and_compare();

        // Random operands, random backpressure and input gaps
        rnd_rdy = 1'b1;
        for (int op = 0; op < 40; op++) begin
            n = $urandom_range(1, MW);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                wa = 16'($urandom);
                wb = 16'($urandom);
                if ($urandom_range(0, 3) == 0) wb = ~wa;
                send_word(wa, wb, 1'($urandom_range(0, 1)), 1'(i == n - 1));
            end
        end
        drain_and_compare();

        // Reset in the middle of a 4-word operand
        send_word(16'h1111, 16'h2222, 1'b0, 1'b0);
        send_word(16'h3333, 16'h4444, 1'b0, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        obs_q.delete();
        m_a = '0; m_b = '0; m_n = 0;
        chk_all_zero("midrst");
        send_word(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("post_rst_idx0", 32'(SUM), 32'h0000);
        send_word(16'h0001, 16'h0000, 1'b0, 1'b1);
        chk("post_rst_sum1", 32'(SUM), 32'h0002);
        chk("post_rst_co",   32'(CO), 0);
        chk("post_rst_idx1", 32'(IDX), 1);
        drain_and_compare();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
